// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: frames one byte, generates the PS/2 clock, aborts on host inhibit.
// Define PS2_TX_RETRY_EN to retransmit an aborted frame once the bus is idle again.
module ps2_device_tx #(
    parameter int HALF_PERIOD = 2000,
    parameter int BUS_IDLE    = 2500
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] send_byte,
    input  logic       send_valid,
    output logic       send_ready,
    output logic       tx_done,
    output logic       tx_aborted,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_BUS, S_SETUP, S_LOW, S_DONE
    } state_t;

    localparam logic [15:0] HP_LAST      = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] IDLE_LAST    = 16'(BUS_IDLE - 1);
    // The first SETUP cycles still see the clock low we drove in LOW (pin release + sync delay).
    localparam logic [15:0] INHIBIT_FROM = 16'd3;
    localparam logic [3:0]  LAST_BIT     = 4'd10;

    state_t      state_q;
    logic [10:0] frame_q;
    logic [15:0] phase_q;
    logic [15:0] phase_d;
    logic [3:0]  bit_idx_q;
    logic [3:0]  bit_idx_d;
    logic [1:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic        send_ready_q;
    logic        tx_done_q;
    logic        tx_aborted_q;
    logic        clk_oe_q;
    logic        dat_oe_q;
    logic        clk_s;
    logic        dat_s;

    assign clk_s     = clk_sync_q[1];
    assign dat_s     = dat_sync_q[1];
    assign phase_d   = phase_q + 16'd1;
    assign bit_idx_d = bit_idx_q + 4'd1;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            phase_q      <= '0;
            bit_idx_q    <= '0;
            send_ready_q <= 1'b1;
            tx_done_q    <= 1'b0;
            tx_aborted_q <= 1'b0;
            clk_oe_q     <= 1'b0;
            dat_oe_q     <= 1'b0;
        end else begin
            tx_done_q    <= 1'b0;
            tx_aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (send_valid) begin
                        frame_q      <= {1'b1, ~^send_byte, send_byte, 1'b0};
                        phase_q      <= '0;
                        send_ready_q <= 1'b0;
                        state_q      <= S_WAIT_BUS;
                    end
                end
                S_WAIT_BUS: begin
                    if (clk_s && dat_s) begin
                        if (phase_q == IDLE_LAST) begin
                            phase_q   <= '0;
                            bit_idx_q <= '0;
                            dat_oe_q  <= ~frame_q[0];
                            clk_oe_q  <= 1'b0;
                            state_q   <= S_SETUP;
                        end else begin
                            phase_q <= phase_d;
                        end
                    end else begin
                        phase_q <= '0;
                    end
                end
                S_SETUP: begin
                    if (phase_q >= INHIBIT_FROM && !clk_s) begin
                        clk_oe_q     <= 1'b0;
                        dat_oe_q     <= 1'b0;
                        tx_aborted_q <= 1'b1;
                        phase_q      <= '0;
                        bit_idx_q    <= '0;
`ifdef PS2_TX_RETRY_EN
                        state_q      <= S_WAIT_BUS;
`else
                        send_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
`endif
                    end else if (phase_q == HP_LAST) begin
                        phase_q  <= '0;
                        clk_oe_q <= 1'b1;
                        state_q  <= S_LOW;
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                S_LOW: begin
                    if (phase_q == HP_LAST) begin
                        phase_q  <= '0;
                        clk_oe_q <= 1'b0;
                        if (bit_idx_q == LAST_BIT) begin
                            dat_oe_q  <= 1'b0;
                            tx_done_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            dat_oe_q  <= ~frame_q[bit_idx_d];
                            state_q   <= S_SETUP;
                        end
                    end else begin
                        phase_q <= phase_d;
                    end
                end
                S_DONE: begin
                    bit_idx_q    <= '0;
                    send_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign send_ready = send_ready_q;
    assign tx_done    = tx_done_q;
    assign tx_aborted = tx_aborted_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: table of bytes with expected 11-bit frames, pull-up pin model,
// bus-side decoder, and hand sequences for bus-busy, host inhibit and mid-frame reset.
module tb_ps2_device_tx;
    localparam int HP = 4;
    localparam int BI = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] send_byte = '0;
    logic       send_valid = 1'b0;
    logic       send_ready, tx_done, tx_aborted, ps2_clk_oe, ps2_dat_oe;
    logic       host_clk = 1'b1;
    logic       host_dat = 1'b1;
    logic       pin_clk, pin_dat;

    assign pin_clk = ~ps2_clk_oe & host_clk;
    assign pin_dat = ~ps2_dat_oe & host_dat;

    ps2_device_tx #(.HALF_PERIOD(HP), .BUS_IDLE(BI)) dut (
        .CLOCK_50(clk), .reset(reset), .send_byte(send_byte), .send_valid(send_valid),
        .send_ready(send_ready), .tx_done(tx_done), .tx_aborted(tx_aborted),
        .ps2_clk_in(pin_clk), .ps2_dat_in(pin_dat),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [10:0] f;
    } vec_t;
    vec_t tbl[5];

    int          tests = 0;
    int          fails = 0;
    logic [10:0] exp_q[$];

    // bus-side decoder: host samples data on device-driven falling clock edges
    logic [3:0]  mon_bits = '0;
    logic [10:0] shreg = '0;
    logic [10:0] last_frame = '0;
    int          frames_cnt = 0, done_cnt = 0, abort_cnt = 0, clk_pulses = 0, bad_low = 0, lowlen = 0;
    logic        prev_clk = 1'b1, prev_oe = 1'b0, mon_flush = 1'b0;

    always @(negedge clk) begin
        if (mon_flush || reset) begin
            mon_bits = '0;
            lowlen   = 0;
        end else begin
            if (ps2_clk_oe && !prev_oe) clk_pulses++;
            if (!pin_clk && prev_clk && ps2_clk_oe) begin
                shreg[mon_bits] = pin_dat;
                mon_bits = mon_bits + 4'd1;
                if (mon_bits == 4'd11) begin
                    last_frame = shreg;
                    frames_cnt++;
                    mon_bits = '0;
                end
            end
            if (!pin_clk && ps2_clk_oe) lowlen++;
            if (pin_clk && !prev_clk) begin
                if (lowlen != 0 && lowlen != HP) bad_low++;
                lowlen = 0;
            end
        end
        if (tx_done) done_cnt++;
        if (tx_aborted) abort_cnt++;
        prev_clk = pin_clk;
        prev_oe  = ps2_clk_oe;
    end

    int s_done, s_frames, s_bad, s_abort, s_pulses;
    int n, m, k;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic snap;
        s_done = done_cnt; s_frames = frames_cnt; s_bad = bad_low;
        s_abort = abort_cnt; s_pulses = clk_pulses;
    endtask

    task automatic flush;
        mon_flush = 1'b1;
        tick;
        mon_flush = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] b, input logic [10:0] f);
        int w = 0;
        while (!send_ready && w < 200) begin tick; w++; end
        check("ready_wait", 32'(w < 200), 1);
        send_byte = b; send_valid = 1'b1;
        exp_q.push_back(f);
        tick;
        send_valid = 1'b0;
        check("ready_drop", 32'(send_ready), 0);
    endtask

    task automatic wait_setup(output int c);
        c = 0;
        while (!ps2_dat_oe && c < 100) begin tick; c++; end
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!tx_done && c < 500) begin tick; c++; end
    endtask

    task automatic finish_frame;
        logic [10:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h0;
        check("done_cnt", done_cnt, s_done + 1);
        check("frame_cnt", frames_cnt, s_frames + 1);
        check("frame_bits", 32'(last_frame), 32'(e));
        check("low_width", bad_low, s_bad);
        check("no_abort", abort_cnt, s_abort);
        tick;
        check("done_pulse", 32'(tx_done), 0);
        check("ready_back", 32'(send_ready), 1);
    endtask

    task automatic run_vec(input int i);
        snap;
        send_req(tbl[i].b, tbl[i].f);
        wait_setup(n);
        check("setup_lat", n, BI);
        wait_done(m);
        check("frame_len", m, 22 * HP);
        finish_frame;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h1C, 11'h438};
        tbl[1] = '{8'hF0, 11'h7E0};
        tbl[2] = '{8'h00, 11'h600};
        tbl[3] = '{8'hFF, 11'h7FE};
        tbl[4] = '{8'h01, 11'h402};

        #2 reset = 1'b1;
        #1;
        check("rst_ready", 32'(send_ready), 1);
        check("rst_done", 32'(tx_done), 0);
        check("rst_abort", 32'(tx_aborted), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 0);
        repeat (3) tick;
        reset = 1'b0;
        repeat (3) tick;

        for (int i = 0; i < 5; i++) run_vec(i);

        // data line held low by the host when the request arrives
        snap;
        host_dat = 1'b0;
        send_req(8'hA5, 11'h74A);
        repeat (20) tick;
        check("hold_no_clk", clk_pulses, s_pulses);
        check("hold_no_setup", 32'(ps2_dat_oe), 0);
        host_dat = 1'b1;
        k = 0;
        while (!ps2_clk_oe && k < 100) begin tick; k++; end
        check("idle_after_release", 32'(k >= BI && k <= BI + 2 + HP), 1);
        wait_done(m);
        check("frame_len_tail", m, 21 * HP);
        finish_frame;

        // host inhibits during the bit-5 SETUP phase
        snap;
        send_req(8'h3C, 11'h678);
        wait_setup(n);
        k = 0;
        while (!(mon_bits == 4'd5 && !ps2_clk_oe) && k < 200) begin tick; k++; end
        check("reach_bit5", 32'(k < 200), 1);
        tick;
        host_clk = 1'b0;
        k = 0;
        while (!tx_aborted && k < 20) begin tick; k++; end
        check("abort_lat", k, 3);
        check("abort_clk_oe", 32'(ps2_clk_oe), 0);
        check("abort_dat_oe", 32'(ps2_dat_oe), 0);
        tick;
        check("abort_pulse", 32'(tx_aborted), 0);
        check("abort_cnt", abort_cnt, s_abort + 1);
`ifdef PS2_TX_RETRY_EN
        check("retry_ready", 32'(send_ready), 0);
        flush;
        host_clk = 1'b1;
        snap;
        wait_done(m);
        check("retry_done", 32'(m < 500), 1);
        finish_frame;
`else
        check("drop_ready", 32'(send_ready), 1);
        exp_q.delete();
        flush;
        host_clk = 1'b1;
        snap;
        repeat (40) tick;
        check("drop_no_clk", clk_pulses, s_pulses);
        check("drop_no_done", done_cnt, s_done);
`endif

        // reset while bit 3 is being clocked low
        snap;
        send_req(8'h1C, 11'h438);
        wait_setup(n);
        k = 0;
        while (!(mon_bits == 4'd4 && ps2_clk_oe) && k < 200) begin tick; k++; end
        check("reach_bit3", 32'(k < 200), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_async_dat_oe", 32'(ps2_dat_oe), 0);
        check("rst_async_ready", 32'(send_ready), 1);
        check("rst_async_done", 32'(tx_done), 0);
        tick;
        reset = 1'b0;
        exp_q.delete();
        flush;
        snap;
        repeat (100) tick;
        check("rst_no_done", done_cnt, s_done);
        check("rst_no_abort", abort_cnt, s_abort);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
